// File: rtl/types.sv
// Shared CPU types: ALU opcodes, operand routing enums, execute-stage state and flag-update masks.
package types;

    localparam int unsigned DATA_W = 4;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_ADC,
        ALU_ADC_NO_DEC,
        ALU_SUB,
        ALU_SBC,
        ALU_CP,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOT,
        ALU_RRC,
        ALU_RLC
    } alu_op;

    typedef enum logic [2:0] {
        SRC_REG_A,
        SRC_REG_B,
        SRC_MEM_X,
        SRC_MEM_Y,
        SRC_IMM
    } operand_src;

    typedef enum logic [2:0] {
        DST_REG_A,
        DST_REG_B,
        DST_MEM_X,
        DST_MEM_Y,
        DST_NONE
    } operand_dest;

    typedef enum logic [2:0] {
        IDLE,
        READ_A,
        LOAD_A,
        READ_B,
        LOAD_B,
        EXEC
    } exec_state_t;

    // Operation context held from start until writeback.
    typedef struct packed {
        alu_op       op;
        operand_src  src_a;
        operand_src  src_b;
        operand_dest dest;
    } exec_ctx_t;

    // {Z,C} flags that an operation updates; D only changes through a direct flag load.
    function automatic logic [1:0] alu_flag_mask(alu_op op);
        logic [1:0] mask;
        mask = 2'b00;
        case (op)
            ALU_ADD, ALU_ADC, ALU_ADC_NO_DEC, ALU_SUB, ALU_SBC,
            ALU_RRC, ALU_RLC, ALU_CP:               mask = 2'b11;
            ALU_AND, ALU_OR, ALU_XOR, ALU_NOT:      mask = 2'b10;
            default:                                mask = 2'b00;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU: binary/BCD add and subtract, logic ops, rotate through carry.
module alu
    import types::*;
(
    input  alu_op              op,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    input  logic               carry_in,
    input  logic               decimal,
    output logic [DATA_W-1:0]  result,
    output logic               flag_carry_out,
    output logic               flag_zero_out
);

    localparam int unsigned W1 = DATA_W + 1;

    logic [W1-1:0] wide;
    logic          cin;

    always_comb begin
        wide           = '0;
        result         = '0;
        flag_carry_out = 1'b0;
        cin            = (op == ALU_ADC || op == ALU_ADC_NO_DEC || op == ALU_SBC) ? carry_in : 1'b0;
        case (op)
            ALU_ADD, ALU_ADC, ALU_ADC_NO_DEC: begin
                wide = W1'(a) + W1'(b) + W1'(cin);
                if (decimal && op != ALU_ADC_NO_DEC && wide > W1'(9)) begin
                    wide           = wide + W1'(6);
                    flag_carry_out = 1'b1;
                end else begin
                    flag_carry_out = wide[DATA_W];
                end
                result = wide[DATA_W-1:0];
            end
            // Carry acts as borrow; compare is always binary.
            ALU_SUB, ALU_SBC, ALU_CP: begin
                wide           = W1'(a) - W1'(b) - W1'(cin);
                flag_carry_out = wide[DATA_W];
                if (decimal && op != ALU_CP && wide[DATA_W]) begin
                    wide = wide - W1'(6);
                end
                result = wide[DATA_W-1:0];
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOT: result = ~a;
            ALU_RRC: begin
                result         = {carry_in, a[DATA_W-1:1]};
                flag_carry_out = a[0];
            end
            ALU_RLC: begin
                result         = {a[DATA_W-2:0], carry_in};
                flag_carry_out = a[DATA_W-1];
            end
            default: result = '0;
        endcase
    end

    assign flag_zero_out = (result == '0);

endmodule

// File: rtl/alu_exec.sv
// Execute stage: gathers operands from regs/memory/immediate, drives the ALU,
// commits the result and owns the architectural C/Z/D flag register.
module alu_exec
    import types::*;
#(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  alu_op                 op,
    input  operand_src            src_a,
    input  operand_src            src_b,
    input  operand_dest           dest,
    input  logic [DATA_W-1:0]     imm,
    input  logic [DATA_W-1:0]     reg_a,
    input  logic [DATA_W-1:0]     reg_b,
    input  logic [ADDR_WIDTH-1:0] x_addr,
    input  logic [ADDR_WIDTH-1:0] y_addr,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_W-1:0]     mem_read_data,
    output logic                  mem_write_en,
    output logic [DATA_W-1:0]     mem_write_data,
    output logic                  reg_write_en,
    output logic                  reg_write_sel,
    output logic [DATA_W-1:0]     reg_write_data,
    input  logic                  flag_write_en,
    input  logic [2:0]            flag_write_data,
    output logic                  flag_carry,
    output logic                  flag_zero,
    output logic                  flag_decimal,
    output logic                  busy,
    output logic                  done
);

    exec_state_t           state_q, state_d;
    exec_ctx_t             ctx_q, ctx_d;
    logic [ADDR_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [DATA_W-1:0]     temp_a_q, temp_a_d, temp_b_q, temp_b_d;
    logic [2:0]            flags_d;
    logic                  pend_c_q, pend_c_d, pend_z_q, pend_z_d;
    logic [1:0]            flag_mask;

    logic                  mem_read_en_d, mem_write_en_d, reg_write_en_d, reg_write_sel_d;
    logic                  busy_d, done_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_W-1:0]     mem_write_data_d, reg_write_data_d;

    logic [DATA_W-1:0]     alu_result;
    logic                  alu_carry, alu_zero;

    function automatic logic is_mem(operand_src s);
        return (s == SRC_MEM_X) || (s == SRC_MEM_Y);
    endfunction

    function automatic logic [DATA_W-1:0] operand_value(input operand_src s,
                                                        input logic [DATA_W-1:0] ra,
                                                        input logic [DATA_W-1:0] rb,
                                                        input logic [DATA_W-1:0] im);
        logic [DATA_W-1:0] v;
        case (s)
            SRC_REG_A: v = ra;
            SRC_REG_B: v = rb;
            SRC_IMM:   v = im;
            default:   v = '0;
        endcase
        return v;
    endfunction

    assign flag_mask = alu_flag_mask(ctx_q.op);

    // Next state, operand capture and flag register update.
    always_comb begin
        state_d  = state_q;
        ctx_d    = ctx_q;
        x_d      = x_q;
        y_d      = y_q;
        temp_a_d = temp_a_q;
        temp_b_d = temp_b_q;
        flags_d  = {flag_decimal, flag_zero, flag_carry};
        case (state_q)
            IDLE: begin
                if (flag_write_en && !done) begin
                    flags_d = flag_write_data;
                end
                if (start) begin
                    ctx_d    = '{op: op, src_a: src_a, src_b: src_b, dest: dest};
                    x_d      = x_addr;
                    y_d      = y_addr;
                    temp_a_d = operand_value(src_a, reg_a, reg_b, imm);
                    temp_b_d = operand_value(src_b, reg_a, reg_b, imm);
                    if (is_mem(src_a)) begin
                        state_d = READ_A;
                    end else if (is_mem(src_b)) begin
                        state_d = READ_B;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            READ_A: state_d = LOAD_A;
            LOAD_A: begin
                temp_a_d = mem_read_data;
                state_d  = is_mem(ctx_q.src_b) ? READ_B : EXEC;
            end
            READ_B: state_d = LOAD_B;
            LOAD_B: begin
                temp_b_d = mem_read_data;
                state_d  = EXEC;
            end
            EXEC: begin
                if (flag_mask[0]) flags_d[0] = pend_c_q;
                if (flag_mask[1]) flags_d[1] = pend_z_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ALU sees the operands as they will be on entry to EXEC so the writeback can be registered.
    alu u_alu (
        .op             (ctx_d.op),
        .a              (temp_a_d),
        .b              (temp_b_d),
        .carry_in       (flags_d[0]),
        .decimal        (flags_d[2]),
        .result         (alu_result),
        .flag_carry_out (alu_carry),
        .flag_zero_out  (alu_zero)
    );

    // Registered output decode for the state being entered.
    always_comb begin
        mem_read_en_d    = 1'b0;
        mem_addr_d       = '0;
        mem_write_en_d   = 1'b0;
        mem_write_data_d = '0;
        reg_write_en_d   = 1'b0;
        reg_write_sel_d  = 1'b0;
        reg_write_data_d = '0;
        done_d           = 1'b0;
        pend_c_d         = pend_c_q;
        pend_z_d         = pend_z_q;
        busy_d           = (state_d != IDLE);
        case (state_d)
            READ_A: begin
                mem_read_en_d = 1'b1;
                mem_addr_d    = (ctx_d.src_a == SRC_MEM_Y) ? y_d : x_d;
            end
            READ_B: begin
                mem_read_en_d = 1'b1;
                mem_addr_d    = (ctx_d.src_b == SRC_MEM_Y) ? y_d : x_d;
            end
            EXEC: begin
                done_d   = 1'b1;
                pend_c_d = alu_carry;
                pend_z_d = alu_zero;
                if (ctx_d.op != ALU_CP) begin
                    case (ctx_d.dest)
                        DST_REG_A, DST_REG_B: begin
                            reg_write_en_d   = 1'b1;
                            reg_write_sel_d  = (ctx_d.dest == DST_REG_B);
                            reg_write_data_d = alu_result;
                        end
                        DST_MEM_X, DST_MEM_Y: begin
                            mem_write_en_d   = 1'b1;
                            mem_addr_d       = (ctx_d.dest == DST_MEM_Y) ? y_d : x_d;
                            mem_write_data_d = alu_result;
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            ctx_q          <= '{op: ALU_ADD, src_a: SRC_REG_A, src_b: SRC_REG_A, dest: DST_REG_A};
            x_q            <= '0;
            y_q            <= '0;
            temp_a_q       <= '0;
            temp_b_q       <= '0;
            pend_c_q       <= 1'b0;
            pend_z_q       <= 1'b0;
            flag_decimal   <= 1'b0;
            flag_zero      <= 1'b0;
            flag_carry     <= 1'b0;
            mem_read_en    <= 1'b0;
            mem_addr       <= '0;
            mem_write_en   <= 1'b0;
            mem_write_data <= '0;
            reg_write_en   <= 1'b0;
            reg_write_sel  <= 1'b0;
            reg_write_data <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q        <= state_d;
            ctx_q          <= ctx_d;
            x_q            <= x_d;
            y_q            <= y_d;
            temp_a_q       <= temp_a_d;
            temp_b_q       <= temp_b_d;
            pend_c_q       <= pend_c_d;
            pend_z_q       <= pend_z_d;
            {flag_decimal, flag_zero, flag_carry} <= flags_d;
            mem_read_en    <= mem_read_en_d;
            mem_addr       <= mem_addr_d;
            mem_write_en   <= mem_write_en_d;
            mem_write_data <= mem_write_data_d;
            reg_write_en   <= reg_write_en_d;
            reg_write_sel  <= reg_write_sel_d;
            reg_write_data <= reg_write_data_d;
            busy           <= busy_d;
            done           <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: expected writeback/flags are queued at issue and compared when done fires.
module tb_alu_exec;
    import types::*;

    localparam int unsigned AW = 12;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    alu_op          op = ALU_ADD;
    operand_src     src_a = SRC_REG_A;
    operand_src     src_b = SRC_REG_A;
    operand_dest    dest = DST_NONE;
    logic [3:0]     imm = '0;
    logic [3:0]     reg_a = '0;
    logic [3:0]     reg_b = '0;
    logic [AW-1:0]  x_addr = '0;
    logic [AW-1:0]  y_addr = '0;
    logic           mem_read_en;
    logic [AW-1:0]  mem_addr;
    logic [3:0]     mem_read_data = '0;
    logic           mem_write_en;
    logic [3:0]     mem_write_data;
    logic           reg_write_en;
    logic           reg_write_sel;
    logic [3:0]     reg_write_data;
    logic           flag_write_en = 1'b0;
    logic [2:0]     flag_write_data = '0;
    logic           flag_carry, flag_zero, flag_decimal;
    logic           busy, done;

    alu_exec #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .dest(dest), .imm(imm),
        .reg_a(reg_a), .reg_b(reg_b), .x_addr(x_addr), .y_addr(y_addr),
        .mem_read_en(mem_read_en), .mem_addr(mem_addr), .mem_read_data(mem_read_data),
        .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
        .reg_write_en(reg_write_en), .reg_write_sel(reg_write_sel), .reg_write_data(reg_write_data),
        .flag_write_en(flag_write_en), .flag_write_data(flag_write_data),
        .flag_carry(flag_carry), .flag_zero(flag_zero), .flag_decimal(flag_decimal),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read data memory, contents set by the stimulus.
    logic [3:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (mem_read_en) mem_read_data <= mem[mem_addr];

    int wr_viol = 0;
    always @(negedge clk) if ((mem_write_en || reg_write_en) && !done) wr_viol++;

    typedef struct {
        int lat;
        int n_rd;
        int rd_addr;
        int rw_en;
        int rw_sel;
        int rw_data;
        int mw_en;
        int mw_addr;
        int mw_data;
        int flags;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail = 0;

    function automatic exp_t mk_exp(int lat, int n_rd, int rd_addr, int rw_en, int rw_sel, int rw_data,
                                    int mw_en, int mw_addr, int mw_data, int flags);
        exp_t e;
        e.lat = lat; e.n_rd = n_rd; e.rd_addr = rd_addr;
        e.rw_en = rw_en; e.rw_sel = rw_sel; e.rw_data = rw_data;
        e.mw_en = mw_en; e.mw_addr = mw_addr; e.mw_data = mw_data; e.flags = flags;
        return e;
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int flags_now();
        return int'({flag_decimal, flag_zero, flag_carry});
    endfunction

    task automatic set_flags(input int fd);
        @(negedge clk);
        flag_write_data = 3'(fd);
        flag_write_en   = 1'b1;
        @(negedge clk);
        flag_write_en   = 1'b0;
        check("set_flags", flags_now(), fd);
    endtask

    task automatic run_op(input string tag, input alu_op o, input operand_src sa, input operand_src sb,
                          input operand_dest d, input int im, input int ra, input int rb,
                          input int xa, input int ya, input logic fwe, input int fd,
                          input logic poke, input exp_t e);
        exp_t x;
        int   cyc, n_rd, early, rd_first, rd_last;
        sb_q.push_back(e);
        @(negedge clk);
        op = o; src_a = sa; src_b = sb; dest = d;
        imm = 4'(im); reg_a = 4'(ra); reg_b = 4'(rb);
        x_addr = AW'(xa); y_addr = AW'(ya);
        flag_write_en = fwe; flag_write_data = 3'(fd);
        start = 1'b1;
        cyc = 0; n_rd = 0; early = 0; rd_first = 0; rd_last = 0;
        do begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            flag_write_en = 1'b0;
            if (mem_read_en) begin
                if (n_rd == 0) rd_first = int'(mem_addr);
                rd_last = int'(mem_addr);
                n_rd++;
            end
            if (!done && (mem_write_en || reg_write_en)) early++;
        end while (!done && cyc < 12);
        x = sb_q.pop_front();
        check({tag, ".done"}, int'(done), 1);
        check({tag, ".latency"}, cyc, x.lat);
        check({tag, ".busy"}, int'(busy), 1);
        check({tag, ".reads"}, n_rd, x.n_rd);
        check({tag, ".early_wr"}, early, 0);
        if (x.n_rd > 0) begin
            check({tag, ".rd_first"}, rd_first, x.rd_addr);
            check({tag, ".rd_last"}, rd_last, x.rd_addr);
        end
        check({tag, ".reg_we"}, int'(reg_write_en), x.rw_en);
        if (x.rw_en != 0) begin
            check({tag, ".reg_sel"}, int'(reg_write_sel), x.rw_sel);
            check({tag, ".reg_data"}, int'(reg_write_data), x.rw_data);
        end
        check({tag, ".mem_we"}, int'(mem_write_en), x.mw_en);
        if (x.mw_en != 0) begin
            check({tag, ".mem_addr"}, int'(mem_addr), x.mw_addr);
            check({tag, ".mem_data"}, int'(mem_write_data), x.mw_data);
        end
        if (poke) begin
            // Start and a flag load while EXEC is active must both be dropped.
            op = ALU_ADD; src_a = SRC_IMM; src_b = SRC_IMM; dest = DST_REG_A; imm = 4'h5;
            flag_write_en = 1'b1; flag_write_data = 3'b111;
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        flag_write_en = 1'b0;
        check({tag, ".flags"}, flags_now(), x.flags);
        check({tag, ".idle_busy"}, int'(busy), 0);
        check({tag, ".idle_done"}, int'(done), 0);
        if (poke) begin
            @(negedge clk);
            check({tag, ".ignored_done"}, int'(done), 0);
            check({tag, ".ignored_busy"}, int'(busy), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 4'h0;
        mem[12'h123] = 4'h9;
        mem[12'h200] = 4'h3;
        mem[12'h3F0] = 4'h5;

        #12;
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.flags", flags_now(), 0);
        check("rst.enables", int'({mem_read_en, mem_write_en, reg_write_en}), 0);
        check("rst.addr", int'(mem_addr), 0);
        check("rst.data", int'({reg_write_data, mem_write_data}), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // ADD 7+8 -> F, reg A
        run_op("add", ALU_ADD, SRC_REG_A, SRC_REG_B, DST_REG_A, 0, 7, 8, 0, 0, 1'b0, 0, 1'b0,
               mk_exp(1, 0, 0, 1, 0, 'hF, 0, 0, 0, 3'b000));
        // Carry loaded alongside start feeds ADC: 7+8+1 = 0x10
        run_op("adc", ALU_ADC, SRC_REG_A, SRC_REG_B, DST_REG_B, 0, 7, 8, 0, 0, 1'b1, 3'b001, 1'b0,
               mk_exp(1, 0, 0, 1, 1, 0, 0, 0, 0, 3'b011));
        set_flags(3'b100);
        // BCD 9+1 = 10 -> 0 with carry, written back to X
        run_op("dec_add", ALU_ADD, SRC_MEM_X, SRC_IMM, DST_MEM_X, 1, 0, 0, 'h123, 0, 1'b0, 0, 1'b0,
               mk_exp(3, 1, 'h123, 0, 0, 0, 1, 'h123, 0, 3'b111));
        // Two reads of the same X location; ADC_NO_DEC ignores D: 3+3+1 = 7
        run_op("two_mem", ALU_ADC_NO_DEC, SRC_MEM_X, SRC_MEM_X, DST_REG_A, 0, 0, 0, 'h200, 0, 1'b0, 0, 1'b0,
               mk_exp(5, 2, 'h200, 1, 0, 7, 0, 0, 0, 3'b100));
        // BCD 2-5 = 7 with borrow, via Y
        run_op("dec_sub", ALU_SUB, SRC_REG_A, SRC_MEM_Y, DST_MEM_Y, 0, 2, 0, 0, 'h3F0, 1'b0, 0, 1'b0,
               mk_exp(3, 1, 'h3F0, 0, 0, 0, 1, 'h3F0, 7, 3'b101));
        set_flags(3'b000);
        // CP 0-1: no writeback, borrow set
        run_op("cp", ALU_CP, SRC_REG_A, SRC_REG_B, DST_REG_A, 0, 0, 1, 0, 0, 1'b0, 0, 1'b1,
               mk_exp(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001));
        // AND F&0 -> 0, Z set, C preserved
        run_op("and", ALU_AND, SRC_REG_A, SRC_IMM, DST_REG_B, 0, 'hF, 0, 0, 0, 1'b0, 0, 1'b0,
               mk_exp(1, 0, 0, 1, 1, 0, 0, 0, 0, 3'b011));
        // RRC of 4 with C=1 -> A, C=0
        run_op("rrc", ALU_RRC, SRC_REG_B, SRC_IMM, DST_REG_A, 0, 0, 4, 0, 0, 1'b0, 0, 1'b0,
               mk_exp(1, 0, 0, 1, 0, 'hA, 0, 0, 0, 3'b000));
        run_op("or", ALU_OR, SRC_REG_A, SRC_REG_B, DST_REG_A, 0, 5, 'hA, 0, 0, 1'b0, 0, 1'b0,
               mk_exp(1, 0, 0, 1, 0, 'hF, 0, 0, 0, 3'b000));
        // Binary 3-5 = E with borrow
        run_op("sbc", ALU_SBC, SRC_REG_A, SRC_IMM, DST_MEM_X, 5, 3, 0, 'h010, 0, 1'b0, 0, 1'b0,
               mk_exp(1, 0, 0, 0, 0, 0, 1, 'h010, 'hE, 3'b001));

        // Reset while in READ_A with freshly loaded flags
        @(negedge clk);
        op = ALU_ADD; src_a = SRC_MEM_X; src_b = SRC_IMM; dest = DST_REG_A;
        x_addr = 12'h050; imm = 4'h1;
        flag_write_en = 1'b1; flag_write_data = 3'b111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flag_write_en = 1'b0;
        check("mid.read_en", int'(mem_read_en), 1);
        check("mid.addr", int'(mem_addr), 'h050);
        check("mid.flags", flags_now(), 3'b111);
        #2 reset_n = 1'b0;
        #1;
        check("mid.rst_busy", int'(busy), 0);
        check("mid.rst_enables", int'({mem_read_en, mem_write_en, reg_write_en, done}), 0);
        check("mid.rst_flags", flags_now(), 0);
        check("mid.rst_addr", int'(mem_addr), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst.busy", int'(busy), 0);
            check("post_rst.done", int'(done), 0);
        end

        run_op("imm_add", ALU_ADD, SRC_IMM, SRC_IMM, DST_REG_B, 3, 0, 0, 0, 0, 1'b0, 0, 1'b0,
               mk_exp(1, 0, 0, 1, 1, 6, 0, 0, 0, 3'b000));

        check("wr_outside_exec", wr_viol, 0);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute stage of the CPU core, directly upstream and downstream of the existing `alu`. It gathers the two 4-bit operands from register A/B, memory (MX/MY) or an immediate, and drives `alu` with the op and the current C and D flags. It then commits the result to a register or memory, and owns the architectural C/Z/D flag register. The decoder issues one operation per `start` pulse and waits for `done`.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: data memory address width.

Ports:
- `clk` in 1: sole clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: accept the operation below. Honored only when `busy`=0.
- `op` in `alu_op`: ALU operation, using the shared `types` enum.
- `src_a`, `src_b` in `operand_src`: REG_A, REG_B, MEM_X, MEM_Y, IMM.
- `dest` in `operand_dest`: REG_A, REG_B, MEM_X, MEM_Y, NONE.
- `imm` in 4: immediate operand.
- `reg_a`, `reg_b` in 4: current register values.
- `x_addr`, `y_addr` in `ADDR_WIDTH`: current X/Y pointers.
- `mem_read_en` out 1, `mem_addr` out `ADDR_WIDTH`, `mem_read_data` in 4.
  - Synchronous read: data is valid the cycle after `mem_read_en`.
- `mem_write_en` out 1, `mem_write_data` out 4.
- `reg_write_en` out 1, `reg_write_sel` out 1 (0=A, 1=B), `reg_write_data` out 4.
- `flag_write_en` in 1, `flag_write_data` in 3 {D,Z,C}: direct flag load (SCF/RCF/SDF etc.).
- `flag_carry`, `flag_zero`, `flag_decimal` out 1: architectural flags.
- `busy` out 1, `done` out 1.

## Operation
State machine: IDLE, READ_A, LOAD_A, READ_B, LOAD_B, EXEC.

Transitions:
- **IDLE**, on `start`:
  - Latch op, srcs, dest, imm and addresses.
  - Any REG/IMM operand is latched into `temp_a`/`temp_b` this cycle.
  - Next state: READ_A if `src_a` is MEM, else READ_B if `src_b` is MEM, else EXEC.
- **READ_x**: `mem_read_en`=1, `mem_addr` = latched X or Y. Next state: LOAD_x.
- **LOAD_x**: `mem_read_data` is sampled into `temp_x`. Next state: READ_B (A only, if `src_b` is MEM), else EXEC.
- **EXEC**:
  - `alu` is combinational on `temp_a`/`temp_b`.
  - `done`=1 for this cycle only.
  - Writeback pulses for one cycle: `reg_write_*` for a REG dest, or `mem_write_en` with `mem_addr` = latched X/Y for a MEM dest.
  - Flags named by `alu_flag_mask(op)` load at the cycle end.
  - Next state: IDLE.

Rules:
- ALU_CP never writes back, regardless of `dest`. It updates C and Z.
- Flag masks:
  - ADD/ADC/ADC_NO_DEC/SUB/SBC/RRC/RLC/CP update C and Z.
  - AND/OR/XOR/NOT update Z only.
  - D is changed only by `flag_write_en`.
- `flag_write_en` is honored only in IDLE and only when `done`=0; it is dropped otherwise.
  - If it coincides with `start`, the new flags load at the end of that cycle and are used by that operation's EXEC.
- `start` while `busy`=1 is ignored, with no queuing.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values (asynchronous):
  - State: IDLE.
  - Outputs: all flags 0, `busy`/`done`/all enables 0, data/address outputs 0.
- Latency from the `start` cycle (cycle 0):
  - Reg/imm only: EXEC in cycle 1.
  - One memory operand: EXEC in cycle 3.
  - Two memory operands: EXEC in cycle 5.
- A new `start` is accepted in the cycle after `done`.
- Write enables are never asserted outside EXEC, and `mem_read_en` never outside READ_x.
- When `src_a`=`src_b`=MEM_X, both operands are read separately (two reads).
- Reset mid-operation: immediate return to IDLE with no write pulses. A flag update in progress is discarded.
- Width: result and operands are 4 bits. Flags are 1 bit each, with carry taken directly from `flag_carry_out` of `alu`.

## Structure
- Add the `operand_src` and `operand_dest` enums to the shared `types` package, alongside `alu_op`.
- Add the function `alu_flag_mask(alu_op)` to `types`, returning the {Z,C} update mask.
- Instantiate the existing `alu` as the single sub-module. No other sub-modules.

## Test plan
- Reset asserted mid-READ_A:
  - Outputs go to 0 immediately, the next state is IDLE, and no write enable is ever seen.
- ADD, `reg_a`=7, `reg_b`=8, dest REG_A, D=0:
  - `done` in cycle 1.
  - `reg_write_en`=1, `reg_write_sel`=0, `reg_write_data`=F.
  - Afterwards C=0, Z=0.
- `flag_write_en` {D=0,Z=0,C=1} coincident with `start` ADC 7+8, dest REG_B:
  - `reg_write_data`=0, then C=1, Z=1.
- D=1, ADD, `src_a`=MEM_X (`x_addr`=0x123, memory returns 9), `src_b`=IMM 1, dest MEM_X:
  - `mem_read_en` in cycle 1 with addr 0x123.
  - `done` in cycle 3 with `mem_write_en`, data 0, addr 0x123.
  - Then C=1, Z=1.
- CP, `reg_a`=0, `reg_b`=1, dest REG_A:
  - No write enables; C=1, Z=0.
  - A second `start` in cycle 1 is ignored, with `busy` high only in cycle 1.
- AND F&0 with C=1 beforehand:
  - `reg_write_data`=0, Z=1, C stays 1.
